skullfet_serializer: RTL and testbench
======================================

# skullfet_serializer

Parametrised load-and-shift register built on the SkullFET functional cell style. It accepts a parallel word through a valid/ready handshake, then either shifts it out MSB-first on a serial pin or steps it as a Fibonacci LFSR for a fixed number of cycles. It reports completion with a one-cycle pulse. It sits beside the SkullFET inverter/NAND cells as the first sequential cell-level block, and it inherits their power-good semantics.

## Interface
Parameters:
- WIDTH, 8, register width; legal range 2..32
- LFSR_TAPS, 8'hB8, feedback tap mask (WIDTH bits); bit i set means q[i] feeds the XOR
- SEED, 1, value loaded instead of zero in LFSR mode (WIDTH bits, must be non-zero)

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- VGND  input  1  ground; present only under USE_POWER_PINS
- VPWR  input  1  supply; present only under USE_POWER_PINS
- load_valid  input  1  load request
- load_ready  output  1  high when a load is accepted this cycle
- load_data  input  WIDTH  word to load
- mode  input  1  0 = serialize, 1 = LFSR; sampled only on load acceptance
- sin  input  1  serial input, shifted into q[0] in serialize mode
- sout  output  1  always equal to q[WIDTH-1]
- q  output  WIDTH  register contents
- busy  output  1  high in SHIFT state
- done  output  1  registered one-cycle pulse after the final step

## Operation
- power_good is (VPWR==1 && VGND==0) under USE_POWER_PINS, and constant 1 otherwise.
- While !power_good, every output is X.
- A rising clk edge while !power_good sets all state (q, state, counter, latched mode, done) to X. Only reset recovers the block.
- States:
  - IDLE: load_ready=1, busy=0.
  - SHIFT: load_ready=0, busy=1.
- IDLE with load_valid=1 at an edge:
  - q <= load_data, or SEED if mode=1 and load_data==0.
  - mode is latched, cnt <= 0, state -> SHIFT.
- IDLE with load_valid=0: hold.
- SHIFT, at each edge:
  - Serialize mode: q <= {q[WIDTH-2:0], sin}.
  - LFSR mode: q <= {q[WIDTH-2:0], ^(q & LFSR_TAPS)}; sin is ignored.
  - cnt <= cnt+1.
  - The edge where cnt==WIDTH-1 goes to IDLE and sets done=1 for the following cycle.
- load_valid during SHIFT is ignored; the word is not captured or queued.
- cnt is $clog2(WIDTH+1) bits and never wraps within one job.
- Reset, including mid-SHIFT:
  - q=0, state=IDLE, cnt=0, latched mode=0, done=0, busy=0, load_ready=1.
  - The aborted job produces no done pulse.

## Timing
- Load accepted at edge E0: sout shows load_data[WIDTH-1] from E0.
- Bit load_data[WIDTH-1-i] is on sout from E(i) to E(i+1), for i = 0..WIDTH-1.
- Shift edges are E1..E(WIDTH). At E(WIDTH), q holds the final value, busy falls and done rises.
- done is high from E(WIDTH) to E(WIDTH+1) only.
- Earliest next load is at edge E(WIDTH+1), so peak throughput is one word per WIDTH+1 cycles.
- load_ready is combinational from state only, with no path from load_valid.
- Reset asserted between edges takes effect immediately. Deassertion is synchronous-safe: the first edge after deassertion can accept a load.

## Test plan
- Serialize, WIDTH=8: load 8'hA5 with mode=0, sin held 1.
  - sout over E0..E7 is 1,0,1,0,0,1,0,1.
  - At E8: q=8'hFF, done=1 for exactly one cycle, busy=0.
- LFSR, taps 8'hB8: load 8'h01 with mode=1.
  - q steps through 02, 04, 08, 11, 23, 47, 8E, 1C.
  - done pulses after the 1C step.
- LFSR zero-load: load 8'h00 with mode=1.
  - q=SEED (8'h01) at E0.
  - Same sequence as the previous scenario.
- Handshake: hold load_valid=1 continuously with alternating words.
  - Loads are accepted only at E0, E9, E18, and so on.
  - Words presented during SHIFT are not captured.
  - mode changes mid-job have no effect.
- Reset mid-job: assert reset at cycle 4 of a serialize job.
  - q=0, busy=0 and load_ready=1 immediately.
  - No done pulse follows.
  - After reset deasserts, a new load of 8'h3C serializes correctly.
- Power (USE_POWER_PINS): drop VPWR to 0 for one edge mid-job.
  - All outputs are X.
  - After VPWR is restored, outputs stay X until reset, then return to IDLE values.

Source files
------------

// File: rtl/skullfet_serializer.sv
// Load-and-shift cell: serializes a word MSB-first on sout, or steps it as a Fibonacci LFSR.
// Latency: load at E0, WIDTH shift edges, done pulses for the cycle after E(WIDTH).
// Backpressure: load_ready is high only in IDLE; load_valid during SHIFT is dropped, never queued.
module skullfet_serializer #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 'hB8,
    parameter logic [WIDTH-1:0] SEED      = 'd1
) (
    input  logic             clk,
    input  logic             reset,
`ifdef USE_POWER_PINS
    input  logic             VGND,
    input  logic             VPWR,
`endif
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             mode,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             mode_r, mode_nxt;
    logic             done_r, done_nxt;
    logic             power_good;

`ifdef USE_POWER_PINS
    assign power_good = (VPWR === 1'b1) && (VGND === 1'b0);
`else
    assign power_good = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        cnt_nxt   = cnt;
        mode_nxt  = mode_r;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    // An all-zero LFSR would lock up, so substitute the seed.
                    q_nxt     = (mode && (load_data == '0)) ? SEED : load_data;
                    mode_nxt  = mode;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                q_nxt   = {q_r[WIDTH-2:0], mode_r ? ^(q_r & LFSR_TAPS) : sin};
                cnt_nxt = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Losing power corrupts every flop; only reset brings the cell back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            q_r    <= '0;
            cnt    <= '0;
            mode_r <= 1'b0;
            done_r <= 1'b0;
        end else if (!power_good) begin
            state  <= state_t'(1'bx);
            q_r    <= 'x;
            cnt    <= 'x;
            mode_r <= 1'bx;
            done_r <= 1'bx;
        end else begin
            state  <= state_nxt;
            q_r    <= q_nxt;
            cnt    <= cnt_nxt;
            mode_r <= mode_nxt;
            done_r <= done_nxt;
        end
    end

    assign load_ready = power_good ? (state == IDLE)   : 1'bx;
    assign busy       = power_good ? (state == SHIFT)  : 1'bx;
    assign done       = power_good ? done_r            : 1'bx;
    assign q          = power_good ? q_r               : 'x;
    assign sout       = power_good ? q_r[WIDTH-1]      : 1'bx;

endmodule

// File: tb/tb_skullfet_serializer.sv
// Directed bench for skullfet_serializer (WIDTH=8) with a queue of expected register values.
module tb_skullfet_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       mode;
    logic       sin;
    logic       sout;
    logic [7:0] q;
    logic       busy;
    logic       done;
`ifdef USE_POWER_PINS
    logic       VPWR = 1'b1;
    logic       VGND = 1'b0;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    logic [7:0] lfsr_tbl [8];

    always #5 clk = ~clk;

    skullfet_serializer #(.WIDTH(8), .LFSR_TAPS(8'hB8), .SEED(8'h01)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef USE_POWER_PINS
        .VGND       (VGND),
        .VPWR       (VPWR),
`endif
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .mode       (mode),
        .sin        (sin),
        .sout       (sout),
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop the next expected register value and compare q and sout against it.
    task automatic pop_chk(input string tag, output logic [7:0] ev);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, q);
            ev = '0;
        end else begin
            ev = exp_q.pop_front();
            chk(tag, q, ev);
            chk({tag, "_sout"}, sout, ev[7]);
        end
    endtask

    // Serializer reference: load value, then eight left shifts filling with s.
    task automatic push_ser(input logic [7:0] data, input logic s);
        logic [7:0] m;
        m = data;
        exp_q.push_back(m);
        for (int k = 0; k < 8; k++) begin
            m = {m[6:0], s};
            exp_q.push_back(m);
        end
    endtask

    task automatic run_job(input string tag, input logic [7:0] data, input logic md, input logic s);
        logic [7:0] ev;
        load_valid = 1'b1;
        load_data  = data;
        mode       = md;
        sin        = s;
        chk({tag, "_ready_idle"}, load_ready, 1'b1);
        for (int i = 0; i <= 8; i++) begin
            step();
            if (i == 0) load_valid = 1'b0;
            pop_chk($sformatf("%s_q_E%0d", tag, i), ev);
            chk($sformatf("%s_busy_E%0d", tag, i), busy, (i < 8));
            chk($sformatf("%s_done_E%0d", tag, i), done, (i == 8));
            chk($sformatf("%s_ready_E%0d", tag, i), load_ready, (i == 8));
        end
        step();
        chk({tag, "_done_clear"}, done, 1'b0);
    endtask

    initial begin
        lfsr_tbl = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
        reset = 1'b1; load_valid = 1'b0; load_data = '0; mode = 1'b0; sin = 1'b0;
        #12;
        chk("rst_q", q, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", load_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_sout", sout, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;

        // Serialize A5 with sin=1: sout 1,0,1,0,0,1,0,1 then q=FF.
        push_ser(8'hA5, 1'b1);
        run_job("ser_a5", 8'hA5, 1'b0, 1'b1);

        // LFSR from 01; sin held 1 must be ignored.
        exp_q.push_back(8'h01);
        for (int k = 0; k < 8; k++) exp_q.push_back(lfsr_tbl[k]);
        run_job("lfsr_01", 8'h01, 1'b1, 1'b1);

        // Zero load in LFSR mode starts from SEED.
        exp_q.push_back(8'h01);
        for (int k = 0; k < 8; k++) exp_q.push_back(lfsr_tbl[k]);
        run_job("lfsr_zero", 8'h00, 1'b1, 1'b0);

        // Continuous load_valid: accepted at E0, E9, E18 only; mid-job words and modes ignored.
        push_ser(8'h81, 1'b0);
        load_valid = 1'b1; load_data = 8'h81; mode = 1'b0; sin = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            step();
            pop_chk($sformatf("hs1_q_E%0d", i), e);
            chk($sformatf("hs1_ready_E%0d", i), load_ready, (i == 8));
            load_data = i[0] ? 8'h55 : 8'hAA;
            mode      = ~i[0];
        end
        load_data = 8'h7E; mode = 1'b0;
        push_ser(8'h7E, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            step();
            pop_chk($sformatf("hs2_q_E%0d", i + 9), e);
            chk($sformatf("hs2_done_E%0d", i + 9), done, (i == 8));
            load_data = i[0] ? 8'h0F : 8'hF0;
            mode      = i[0];
        end
        load_data = 8'hC3; mode = 1'b1;
        exp_q.push_back(8'hC3);
        step();
        pop_chk("hs3_q_E18", e);
        chk("hs3_busy_E18", busy, 1'b1);
        load_valid = 1'b0;
        repeat (8) step();
        chk("hs3_done_E26", done, 1'b1);
        step();

        // Reset mid-job: immediate clear, and the aborted job never signals done.
        push_ser(8'hF0, 1'b0);
        load_valid = 1'b1; load_data = 8'hF0; mode = 1'b0; sin = 1'b0;
        step();
        load_valid = 1'b0;
        pop_chk("abort_q_E0", e);
        repeat (4) step();
        exp_q.delete();
        #2 reset = 1'b1;
        #1;
        chk("abort_q", q, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", load_ready, 1'b1);
        chk("abort_done", done, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("abort_nodone_%0d", i), done, 1'b0);
        end
        #2 reset = 1'b0;
        push_ser(8'h3C, 1'b0);
        run_job("post_rst_3c", 8'h3C, 1'b0, 1'b0);

`ifdef USE_POWER_PINS
        // Supply drop mid-job corrupts everything until reset.
        push_ser(8'hA5, 1'b0);
        load_valid = 1'b1; load_data = 8'hA5; mode = 1'b0; sin = 1'b0;
        step();
        load_valid = 1'b0;
        step();
        exp_q.delete();
        VPWR = 1'b0;
        #1;
        chk("pwr_q_x", q, 8'hxx);
        chk("pwr_busy_x", busy, 1'bx);
        chk("pwr_ready_x", load_ready, 1'bx);
        chk("pwr_done_x", done, 1'bx);
        chk("pwr_sout_x", sout, 1'bx);
        step();
        VPWR = 1'b1;
        #1;
        chk("pwr_restored_q_x", q, 8'hxx);
        chk("pwr_restored_busy_x", busy, 1'bx);
        step();
        chk("pwr_still_x", q, 8'hxx);
        reset = 1'b1;
        #1;
        chk("pwr_rst_q", q, 8'h00);
        chk("pwr_rst_busy", busy, 1'b0);
        chk("pwr_rst_ready", load_ready, 1'b1);
        chk("pwr_rst_done", done, 1'b0);
        step();
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
